// File: rtl/stopwatch_pkg.sv
// Shared types and default moduli for the stopwatch core.
// Port widths are fixed, so every modulus must fit in its field.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    localparam int CS_MAX_DEF  = 100;
    localparam int SEC_MAX_DEF = 60;
    localparam int MIN_MAX_DEF = 100;

    localparam int CS_W  = 7;
    localparam int SEC_W = 6;
    localparam int MIN_W = 7;

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses in, displayed time and status out.
interface stopwatch_if;
    import stopwatch_pkg::*;

    logic             i_tick;
    logic             i_start;
    logic             i_lap;
    logic             i_clear;
    logic [CS_W-1:0]  o_cs;
    logic [SEC_W-1:0] o_sec;
    logic [MIN_W-1:0] o_min;
    logic             o_running;
    logic             o_lap;
    logic             o_wrap;

    modport master (
        output i_tick, i_start, i_lap, i_clear,
        input  o_cs, o_sec, o_min, o_running, o_lap, o_wrap
    );

    modport slave (
        input  i_tick, i_start, i_lap, i_clear,
        output o_cs, o_sec, o_min, o_running, o_lap, o_wrap
    );

endinterface

// File: rtl/stopwatch_mod_counter.sv
// Modulo-MAX counter stage; o_carry is combinational so stages chain in one cycle.
module mod_counter #(
    parameter int MAX = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         i_enable,
    input  logic         i_clear,
    output logic [W-1:0] o_val,
    output logic         o_carry
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign o_carry = i_enable && (o_val == LAST);

    always_ff @(posedge clk or posedge areset) begin
        if (areset)
            o_val <= '0;
        else if (i_clear)
            o_val <= '0;
        else if (i_enable)
            o_val <= (o_val == LAST) ? '0 : o_val + 1'b1;
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/pause/lap FSM over a cs/sec/min carry chain, with a
// display register that either tracks the live count or holds a lap capture.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CS_MAX  = CS_MAX_DEF,
    parameter int SEC_MAX = SEC_MAX_DEF,
    parameter int MIN_MAX = MIN_MAX_DEF
) (
    input  logic        clk,
    input  logic        areset,
    stopwatch_if.slave  sw
);

    if (CS_MAX < 2 || CS_MAX > (1 << CS_W)) begin : g_bad_cs
        $error("CS_MAX does not fit the centisecond output");
    end
    if (SEC_MAX < 2 || SEC_MAX > (1 << SEC_W)) begin : g_bad_sec
        $error("SEC_MAX does not fit the seconds output");
    end
    if (MIN_MAX < 2 || MIN_MAX > (1 << MIN_W)) begin : g_bad_min
        $error("MIN_MAX does not fit the minutes output");
    end

    state_t state;

    logic             cnt_en, clr;
    logic             cs_carry, sec_carry, min_carry;
    logic [CS_W-1:0]  cs, cs_nxt, disp_cs;
    logic [SEC_W-1:0] sec, sec_nxt, disp_sec;
    logic [MIN_W-1:0] min, min_nxt, disp_min;
    logic             running, lap_q, wrap;

    // Counting keys off the current state, so a tick on the edge that enters
    // RUN is lost and a tick on the edge that leaves RUN/LAP is kept.
    assign cnt_en = sw.i_tick && (state == RUN || state == LAP);
    assign clr    = sw.i_clear && (state == PAUSE);

    mod_counter #(.MAX(CS_MAX), .W(CS_W)) u_cs (
        .clk(clk), .areset(areset), .i_enable(cnt_en), .i_clear(clr),
        .o_val(cs), .o_carry(cs_carry)
    );

    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk(clk), .areset(areset), .i_enable(cs_carry), .i_clear(clr),
        .o_val(sec), .o_carry(sec_carry)
    );

    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .areset(areset), .i_enable(sec_carry), .i_clear(clr),
        .o_val(min), .o_carry(min_carry)
    );

    // Post-edge live count, so the display register shows the same value the
    // counters will hold (this is what makes a lap capture include its tick).
    always_comb begin
        cs_nxt  = cs;
        sec_nxt = sec;
        min_nxt = min;
        if (clr) begin
            cs_nxt  = '0;
            sec_nxt = '0;
            min_nxt = '0;
        end else begin
            if (cnt_en)    cs_nxt  = cs_carry  ? '0 : cs  + 1'b1;
            if (cs_carry)  sec_nxt = sec_carry ? '0 : sec + 1'b1;
            if (sec_carry) min_nxt = min_carry ? '0 : min + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            disp_cs  <= '0;
            disp_sec <= '0;
            disp_min <= '0;
            running  <= 1'b0;
            lap_q    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            wrap <= min_carry;

            // Display holds only while sitting in LAP; any exit reloads it.
            if (state != LAP || sw.i_start || sw.i_lap) begin
                disp_cs  <= cs_nxt;
                disp_sec <= sec_nxt;
                disp_min <= min_nxt;
            end

            case (state)
                IDLE: begin
                    if (sw.i_start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (sw.i_start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end else if (sw.i_lap) begin
                        state <= LAP;
                        lap_q <= 1'b1;
                    end
                end
                LAP: begin
                    if (sw.i_start) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        lap_q   <= 1'b0;
                    end else if (sw.i_lap) begin
                        state <= RUN;
                        lap_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (sw.i_clear) begin
                        state <= IDLE;
                    end else if (sw.i_start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    lap_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sw.o_cs      = disp_cs;
    assign sw.o_sec     = disp_sec;
    assign sw.o_min     = disp_min;
    assign sw.o_running = running;
    assign sw.o_lap     = lap_q;
    assign sw.o_wrap    = wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: default instance for control/timing,
// a 2/2/2 instance for full rollover.
module tb_stopwatch_core;

    logic clk;
    logic areset;
    int   vectors;
    int   errs;

    stopwatch_if sw ();
    stopwatch_if sw2 ();

    stopwatch_core u_dut (
        .clk(clk), .areset(areset), .sw(sw)
    );

    stopwatch_core #(.CS_MAX(2), .SEC_MAX(2), .MIN_MAX(2)) u_small (
        .clk(clk), .areset(areset), .sw(sw2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic start, input logic lap, input logic clear, input logic tick);
        sw.i_start = start;
        sw.i_lap   = lap;
        sw.i_clear = clear;
        sw.i_tick  = tick;
        @(posedge clk);
        #1;
        sw.i_start = 1'b0;
        sw.i_lap   = 1'b0;
        sw.i_clear = 1'b0;
        sw.i_tick  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic pulse2(input logic start, input logic tick);
        sw2.i_start = start;
        sw2.i_tick  = tick;
        @(posedge clk);
        #1;
        sw2.i_start = 1'b0;
        sw2.i_tick  = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        areset  = 1'b1;
        sw.i_tick = 1'b0; sw.i_start = 1'b0; sw.i_lap = 1'b0; sw.i_clear = 1'b0;
        sw2.i_tick = 1'b0; sw2.i_start = 1'b0; sw2.i_lap = 1'b0; sw2.i_clear = 1'b0;

        #23;
        chk("rst_cs", sw.o_cs, 0);
        chk("rst_sec", sw.o_sec, 0);
        chk("rst_min", sw.o_min, 0);
        chk("rst_running", sw.o_running, 0);
        chk("rst_lap", sw.o_lap, 0);
        chk("rst_wrap", sw.o_wrap, 0);
        areset = 1'b0;

        // start then 150 ticks -> 0:1.50
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_running", sw.o_running, 1);
        ticks(150);
        chk("t150_sec", sw.o_sec, 1);
        chk("t150_cs", sw.o_cs, 50);
        chk("t150_running", sw.o_running, 1);

        // asynchronous reset between edges
        areset = 1'b1;
        #2;
        chk("async_cs", sw.o_cs, 0);
        chk("async_sec", sw.o_sec, 0);
        chk("async_running", sw.o_running, 0);
        #3;
        areset = 1'b0;
        ticks(5);
        chk("idle_tick_cs", sw.o_cs, 0);
        chk("idle_tick_running", sw.o_running, 0);

        // lap capture and release
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(20);
        chk("pre_lap_cs", sw.o_cs, 20);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_cs", sw.o_cs, 20);
        chk("lap_flag", sw.o_lap, 1);
        ticks(30);
        chk("lap_hold_cs", sw.o_cs, 20);
        chk("lap_running", sw.o_running, 1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_release_cs", sw.o_cs, 50);
        chk("lap_release_flag", sw.o_lap, 0);

        // lap with coincident tick captures the incremented value
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        chk("lap_tick_cs", sw.o_cs, 51);
        ticks(3);
        chk("lap_tick_hold", sw.o_cs, 51);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("lap_pause_cs", sw.o_cs, 54);
        chk("lap_pause_running", sw.o_running, 0);
        chk("lap_pause_flag", sw.o_lap, 0);

        // pause ignores ticks, clear zeroes
        ticks(10);
        chk("pause_hold_cs", sw.o_cs, 54);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clear_cs", sw.o_cs, 0);
        chk("clear_running", sw.o_running, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_lap_ignored", sw.o_lap, 0);

        // clear ignored in RUN
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(7);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run_clear_cs", sw.o_cs, 7);
        chk("run_clear_running", sw.o_running, 1);

        // priority: all three from PAUSE -> IDLE, zero
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause2_running", sw.o_running, 0);
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        chk("prio_cs", sw.o_cs, 0);
        chk("prio_running", sw.o_running, 0);
        chk("prio_lap", sw.o_lap, 0);

        // tick coincident with start from IDLE is not counted
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("start_tick_cs", sw.o_cs, 0);
        chk("start_tick_running", sw.o_running, 1);
        ticks(1);
        chk("first_tick_cs", sw.o_cs, 1);

        // minute carry: 6000 ticks total -> 1:0.0
        ticks(5999);
        chk("minute_min", sw.o_min, 1);
        chk("minute_sec", sw.o_sec, 0);
        chk("minute_cs", sw.o_cs, 0);
        chk("minute_wrap", sw.o_wrap, 0);

        // tick coincident with pause is counted, then ignored
        pulse(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pause_tick_cs", sw.o_cs, 1);
        chk("pause_tick_running", sw.o_running, 0);
        ticks(1);
        chk("paused_tick_cs", sw.o_cs, 1);

        // full rollover on the 2/2/2 instance
        pulse2(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) pulse2(1'b0, 1'b1);
        chk("small_min", sw2.o_min, 1);
        chk("small_sec", sw2.o_sec, 1);
        chk("small_cs", sw2.o_cs, 1);
        chk("small_pre_wrap", sw2.o_wrap, 0);
        pulse2(1'b0, 1'b1);
        chk("roll_min", sw2.o_min, 0);
        chk("roll_sec", sw2.o_sec, 0);
        chk("roll_cs", sw2.o_cs, 0);
        chk("roll_wrap", sw2.o_wrap, 1);
        pulse2(1'b0, 1'b0);
        chk("roll_wrap_drop", sw2.o_wrap, 0);
        pulse2(1'b0, 1'b1);
        chk("roll_continue_cs", sw2.o_cs, 1);
        chk("roll_running", sw2.o_running, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
